// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - screen phase controller for the full-screen drawer
// Runs clear/title/flash/play/game-over phases, one registered 160x120 sweep per drawn phase.
module screen_sequencer #(
  parameter int PIXELS       = 19200,
  parameter int FLASH_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic start_key,
  input  logic game_over,
  input  logic frame_tick,
  output logic draw_rst_n,
  output logic show_black,
  output logic show_title,
  output logic flash,
  output logic show_game_over,
  output logic plot,
  output logic game_en,
  output logic busy
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [14:0]   LAST_PIX   = 15'(PIXELS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FLASH_FRAMES - 1);

  localparam logic [2:0] P_CLR_T = 3'd0;
  localparam logic [2:0] P_TITLE = 3'd1;
  localparam logic [2:0] P_WAIT  = 3'd2;
  localparam logic [2:0] P_CLR_G = 3'd3;
  localparam logic [2:0] P_PLAY  = 3'd4;
  localparam logic [2:0] P_GO    = 3'd5;
  localparam logic [2:0] P_HOLD  = 3'd6;

  localparam logic [1:0] K_BLACK = 2'd0;
  localparam logic [1:0] K_TITLE = 2'd1;
  localparam logic [1:0] K_FLASH = 2'd2;
  localparam logic [1:0] K_GO    = 2'd3;

  logic [2:0]    phase, phase_n;
  logic          prep, prep_n;
  logic          sweeping, sweeping_n;
  logic [14:0]   count, count_n;
  logic [FW-1:0] frames, frames_n;
  logic          pending, pending_n;
  logic          flash_ph, flash_ph_n;
  logic [1:0]    kind, kind_n;
  logic          start_q;
  logic          start_edge;

  assign start_edge = start_key & ~start_q;
  assign plot       = busy;

  always_comb begin
    phase_n    = phase;
    prep_n     = prep;
    sweeping_n = sweeping;
    count_n    = count;
    frames_n   = frames;
    pending_n  = pending;
    flash_ph_n = flash_ph;
    kind_n     = kind;
    if (prep) begin
      prep_n     = 1'b0;
      sweeping_n = 1'b1;
      count_n    = '0;
      if (start_edge) pending_n = 1'b1;
    end else if (sweeping) begin
      if (start_edge) pending_n = 1'b1;
      if (count == LAST_PIX) begin
        sweeping_n = 1'b0;
        case (phase)
          P_CLR_T: begin
            phase_n = P_TITLE;
            prep_n  = 1'b1;
            kind_n  = K_TITLE;
          end
          P_TITLE: begin
            phase_n  = P_WAIT;
            frames_n = '0;
          end
          P_WAIT:  frames_n = '0;
          P_CLR_G: phase_n  = P_PLAY;
          P_GO:    phase_n  = P_HOLD;
          default: phase_n  = P_CLR_T;
        endcase
      end else begin
        count_n = count + 15'd1;
      end
    end else begin
      case (phase)
        P_WAIT: begin
          // a pending or fresh start wins over a simultaneous flash expiry
          if (pending || start_edge) begin
            phase_n   = P_CLR_G;
            prep_n    = 1'b1;
            kind_n    = K_BLACK;
            pending_n = 1'b0;
          end else if (frame_tick) begin
            if (frames == LAST_FRAME) begin
              frames_n   = '0;
              prep_n     = 1'b1;
              kind_n     = flash_ph ? K_TITLE : K_FLASH;
              flash_ph_n = ~flash_ph;
            end else begin
              frames_n = frames + 1'b1;
            end
          end
        end
        P_PLAY: begin
          pending_n = 1'b0;
          if (game_over) begin
            phase_n = P_GO;
            prep_n  = 1'b1;
            kind_n  = K_GO;
          end
        end
        P_HOLD: begin
          if (pending || start_edge) begin
            phase_n    = P_CLR_T;
            prep_n     = 1'b1;
            kind_n     = K_BLACK;
            pending_n  = 1'b0;
            flash_ph_n = 1'b0;
          end
        end
        default: prep_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase          <= P_CLR_T;
      prep           <= 1'b1;
      sweeping       <= 1'b0;
      count          <= '0;
      frames         <= '0;
      pending        <= 1'b0;
      flash_ph       <= 1'b0;
      kind           <= K_BLACK;
      start_q        <= 1'b0;
      draw_rst_n     <= 1'b0;
      show_black     <= 1'b0;
      show_title     <= 1'b0;
      flash          <= 1'b0;
      show_game_over <= 1'b0;
      busy           <= 1'b0;
      game_en        <= 1'b0;
    end else begin
      phase          <= phase_n;
      prep           <= prep_n;
      sweeping       <= sweeping_n;
      count          <= count_n;
      frames         <= frames_n;
      pending        <= pending_n;
      flash_ph       <= flash_ph_n;
      kind           <= kind_n;
      start_q        <= start_key;
      draw_rst_n     <= ~prep_n;
      show_black     <= sweeping_n && (kind_n == K_BLACK);
      show_title     <= sweeping_n && (kind_n == K_TITLE);
      flash          <= sweeping_n && (kind_n == K_FLASH);
      show_game_over <= sweeping_n && (kind_n == K_GO);
      busy           <= sweeping_n;
      game_en        <= (phase_n == P_PLAY) && !prep_n && !sweeping_n;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed bench for screen_sequencer
// Output vector: {draw_rst_n, black, title, flash, game_over, plot, game_en, busy}.
module tb_screen_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_key = 1'b0;
  logic game_over = 1'b0;
  logic frame_tick = 1'b0;
  logic draw_rst_n, show_black, show_title, flash, show_game_over, plot, game_en, busy;
  logic [7:0] outs;
  int tests = 0;
  int fails = 0;

  localparam logic [7:0] O_PREP  = 8'h00;
  localparam logic [7:0] O_IDLE  = 8'h80;
  localparam logic [7:0] O_BLACK = 8'hC5;
  localparam logic [7:0] O_TITLE = 8'hA5;
  localparam logic [7:0] O_FLASH = 8'h95;
  localparam logic [7:0] O_GO    = 8'h8D;
  localparam logic [7:0] O_PLAY  = 8'h82;

  screen_sequencer #(.PIXELS(16), .FLASH_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start_key(start_key), .game_over(game_over),
    .frame_tick(frame_tick), .draw_rst_n(draw_rst_n), .show_black(show_black),
    .show_title(show_title), .flash(flash), .show_game_over(show_game_over),
    .plot(plot), .game_en(game_en), .busy(busy)
  );

  always #5 clk = ~clk;

  assign outs = {draw_rst_n, show_black, show_title, flash, show_game_over, plot, game_en, busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(outs), 32'(pat));
    end
  endtask

  task automatic tick(input string tag, input logic [7:0] pat);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check(tag, 32'(outs), 32'(pat));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(outs), 32'(O_PREP));
    rst = 1'b0;
    #1 check("first_prep", 32'(outs), 32'(O_PREP));
    run("clr_t_black", O_BLACK, 16);
    run("title_prep", O_PREP, 1);
    run("title", O_TITLE, 16);
    run("wait_idle", O_IDLE, 1);

    tick("tick1", O_IDLE);
    tick("tick2", O_IDLE);
    tick("tick3_prep", O_PREP);
    run("flash1", O_FLASH, 16);
    run("after_flash1", O_IDLE, 2);
    tick("tick4", O_IDLE);
    tick("tick5", O_IDLE);
    tick("tick6_prep", O_PREP);
    run("title_alt", O_TITLE, 16);
    run("after_title_alt", O_IDLE, 1);
    tick("tick7", O_IDLE);
    tick("tick8", O_IDLE);
    tick("tick9_prep", O_PREP);

    run("flash2_head", O_FLASH, 5);
    start_key = 1'b1;
    run("flash2_tail", O_FLASH, 11);
    run("flash2_end", O_IDLE, 1);
    run("clr_g_prep", O_PREP, 1);
    run("clr_g_black", O_BLACK, 16);
    run("play", O_PLAY, 2);
    start_key = 1'b0;
    run("play_release", O_PLAY, 1);
    start_key = 1'b1;
    run("play_start_ignored", O_PLAY, 2);

    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    check("go_prep_game_en_off", 32'(outs), 32'(O_PREP));
    run("go_head", O_GO, 5);
    game_over = 1'b1;
    run("go_second_pulse", O_GO, 1);
    game_over = 1'b0;
    run("go_tail", O_GO, 10);
    run("hold_start_held", O_IDLE, 4);
    start_key = 1'b0;
    run("hold_released", O_IDLE, 2);
    start_key = 1'b1;
    run("hold_press_prep", O_PREP, 1);
    start_key = 1'b0;
    run("restart_black", O_BLACK, 8);

    #2 rst = 1'b1;
    #1 check("async_rst_outs", 32'(outs), 32'(O_PREP));
    @(negedge clk);
    check("rst_held", 32'(outs), 32'(O_PREP));
    rst = 1'b0;
    #1 check("rst_release_prep", 32'(outs), 32'(O_PREP));
    run("post_rst_black", O_BLACK, 16);
    run("post_rst_title_prep", O_PREP, 1);
    run("post_rst_title", O_TITLE, 16);
    run("post_rst_idle", O_IDLE, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
